reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural register file: 16 x 16-bit general registers.
- Responder end of the register-write interface. It consumes the destination, data, write-enable and byte-lane strobes that the writeback stage drives.
- Provides two registered read ports for the decode/operand-fetch stage and one combinational debug read port.
- Sits between writeback (write side) and decode (read side). Does not handle PC updates.

Parameters:
- NUM_REGS, 16, number of registers; address width is clog2(NUM_REGS) = 4.
- DATA_W, 16, register width; must be 16, since byte lanes are hard-coded as [15:8] and [7:0].
- ZERO_R0, 0, when 1, r0 reads as 0 and writes to r0 are discarded.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- regDest  input  4  write destination register.
- dataIn  input  16  write data.
- we  input  1  write request; qualifies hb/lb.
- hb  input  1  write high byte [15:8].
- lb  input  1  write low byte [7:0].
- rdEn  input  1  read-port advance enable; low holds both read outputs (stall).
- rdAddrA  input  4  read port A address.
- rdAddrB  input  4  read port B address.
- rdDataA  output  16  port A data, registered.
- rdDataB  output  16  port B data, registered.
- dbgAddr  input  4  debug read address.
- dbgData  output  16  combinational debug read of array contents.

Behaviour:
Reset
- rst high at a rising edge clears all registers, rdDataA and rdDataB to 0x0000.
- Reset has priority over any simultaneous write or read.
- Mid-operation reset discards that cycle's write.
- dbgData reads 0x0000 for every address the cycle after reset.

Write side
- At a rising edge with we=1: if hb=1, regs[regDest][15:8] <= dataIn[15:8]; if lb=1, regs[regDest][7:0] <= dataIn[7:0].
- Lanes are independent. we=1 with hb=lb=0 changes nothing.
- hb/lb with we=0 are ignored.
- ZERO_R0=1: writes with regDest=0 are dropped.

Read side
- Latency is 1 cycle. At a rising edge with rdEn=1: rdDataX <= regs[rdAddrX] (pre-edge array value).
- rdEn=0: rdDataA/B hold their previous values; the write side is unaffected by rdEn.
- Both ports may address the same register.
- ZERO_R0=1: address 0 yields 0x0000.

Read-during-write
- Same-edge write and read to the same register: the read returns the OLD value unless the bypass feature is enabled (see below).
- A read one cycle after the write always sees the new value.

Debug port
- dbgData = regs[dbgAddr] combinationally, reflecting committed state only (no bypass).

Out of range
- Addresses are full-range for NUM_REGS=16; no out-of-range handling is required.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when rdEn=1, we=1 and rdAddrX==regDest (and not a dropped r0 write), rdDataX <= merge(regs[rdAddrX], dataIn, hb, lb). Only the strobed byte lanes take dataIn; the other lanes keep the array value. Apply per port independently.
- Undefined: same-edge reads return the pre-write value, so writeback must be separated from operand fetch by at least one cycle.

Decomposition:
- Shared package cpu_pkg: reg_addr_t (logic [3:0]), word_t (logic [15:0]), NUM_REGS constant, byte-lane enable typedef lane_en_t (logic [1:0], {hb, lb}), matching the reg_write encoding used by the pipeline control struct.
- One natural sub-module: rf_lane_merge (combinational: old word, new word, lane_en -> merged word). It is shared by the write path and the bypass path.

Test Plan:
- Reset: preload r3=0xBEEF; assert rst one cycle with we=1, regDest=3, dataIn=0x1234 -> dbgData(r3)=0x0000; rdDataA=rdDataB=0x0000.
- Byte lanes: r5=0x0000. Write we=1, hb=1, lb=0, dataIn=0xAB12 -> r5=0xAB00. Then we=1, hb=0, lb=1, dataIn=0x77CD -> r5=0xABCD. Then we=1, hb=lb=0 -> r5 stays 0xABCD.
- Read latency/stall: r1=0x1111, r2=0x2222; rdAddrA=1, rdAddrB=2, rdEn=1 -> one edge later rdDataA=0x1111, rdDataB=0x2222. Change addresses to 5 with rdEn=0 -> outputs hold 0x1111/0x2222.
- Read-during-write: r7=0x0F0F; same edge we=1, hb=lb=1, regDest=7, dataIn=0x5A5A, rdAddrA=7 -> rdDataA=0x0F0F without bypass, 0x5A5A with REGFILE_BYPASS_EN. With only lb=1: bypass gives 0x0F5A.
- ZERO_R0=1: write r0 with 0xFFFF -> dbgData(r0)=0x0000, rdDataA (addr 0)=0x0000. With ZERO_R0=0, r0 reads back 0xFFFF.
- Random: 10k cycles of random we/hb/lb/addresses/rdEn checked against a reference array model, both with and without REGFILE_BYPASS_EN.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared CPU datapath types: register address, data word and the
//           {hb, lb} byte-lane enable used by the register-write interface.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    // Bit 1 = high byte [15:8], bit 0 = low byte [7:0]
    typedef logic [1:0] lane_en_t;

    localparam lane_en_t LANE_NONE = 2'b00;
    localparam lane_en_t LANE_LO   = 2'b01;
    localparam lane_en_t LANE_HI   = 2'b10;
    localparam lane_en_t LANE_BOTH = 2'b11;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rf_lane_merge.sv
`default_nettype none
// ============================================================================
// Module  : rf_lane_merge
// Purpose : Byte-lane merge: strobed lanes take the new word, the rest keep
//           the old word. Used by both the array write and the read bypass.
// Revision: 1.0 - initial release
// ============================================================================
module rf_lane_merge
    import cpu_pkg::*;
(
    input  word_t    i_old_word,
    input  word_t    i_new_word,
    input  lane_en_t i_lane_en,
    output word_t    o_merged
);

    assign o_merged[15:8] = i_lane_en[1] ? i_new_word[15:8] : i_old_word[15:8];
    assign o_merged[7:0]  = i_lane_en[0] ? i_new_word[7:0]  : i_old_word[7:0];

endmodule : rf_lane_merge
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module  : reg_file
// Purpose : 16 x 16-bit architectural register file with byte-lane writes,
//           two registered read ports and a combinational debug port.
//           Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
// Revision: 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int DATA_W   = 16,    // byte lanes are fixed at [15:8]/[7:0]
    parameter bit ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  reg_addr_t         regDest,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              we,
    input  logic              hb,
    input  logic              lb,
    input  logic              rdEn,
    input  reg_addr_t         rdAddrA,
    input  reg_addr_t         rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    input  reg_addr_t         dbgAddr,
    output logic [DATA_W-1:0] dbgData
);

    localparam int c_NUM_PORTS = 2;

    word_t     r_regs    [NUM_REGS];
    word_t     r_rd_word [c_NUM_PORTS];
    reg_addr_t w_rd_addr [c_NUM_PORTS];

    logic      w_drop;
    lane_en_t  w_wr_lanes;
    word_t     w_wr_word;

    // A write to r0 is squashed to no lanes so the bypass never sees it either
    assign w_drop     = ZERO_R0 && (regDest == '0);
    assign w_wr_lanes = (we && !w_drop) ? {hb, lb} : LANE_NONE;

    rf_lane_merge u_wr_merge (
        .i_old_word (r_regs[regDest]),
        .i_new_word (dataIn),
        .i_lane_en  (w_wr_lanes),
        .o_merged   (w_wr_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_lanes != LANE_NONE) begin
            r_regs[regDest] <= w_wr_word;
        end
    end

    assign w_rd_addr[0] = rdAddrA;
    assign w_rd_addr[1] = rdAddrB;

    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_rd_port
        word_t w_arr_word;
        word_t w_next_word;

        assign w_arr_word = (ZERO_R0 && (w_rd_addr[p] == '0)) ? '0 : r_regs[w_rd_addr[p]];

`ifdef REGFILE_BYPASS_EN
        // w_wr_word is the merged value that regDest is about to commit
        logic w_bypass;
        assign w_bypass    = (w_wr_lanes != LANE_NONE) && (w_rd_addr[p] == regDest);
        assign w_next_word = w_bypass ? w_wr_word : w_arr_word;
`else
        assign w_next_word = w_arr_word;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_word[p] <= '0;
            end else if (rdEn) begin
                r_rd_word[p] <= w_next_word;
            end
        end
    end

    assign rdDataA = r_rd_word[0];
    assign rdDataB = r_rd_word[1];
    assign dbgData = (ZERO_R0 && (dbgAddr == '0)) ? '0 : r_regs[dbgAddr];

endmodule : reg_file
`default_nettype wire
